// File: rtl/class_search_ctrl.sv
// rtl/class_search_ctrl.sv - class hypervector arg-min Hamming search sequencer
// Optional macro CLASS_SEARCH_REJECT_EN adds reject_thresh / pred_reject.
module class_search_ctrl #(
    parameter int NUM_CLASSES = 8,
    parameter int NUM_FRAMES  = 3,
    parameter int FRAME_W     = 64,
    parameter int CLASS_ID_W  = 3,
    parameter int FRAME_IDX_W = 2,
    parameter int DIST_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic [CLASS_ID_W-1:0]  rom_frame_id,
    output logic [FRAME_IDX_W-1:0] rom_frame_index,
    input  logic [FRAME_W-1:0]     rom_class_vec,
    input  logic [FRAME_W-1:0]     query_frame,
    output logic                   done,
    output logic [CLASS_ID_W-1:0]  pred_class,
    output logic [DIST_W-1:0]      pred_dist
`ifdef CLASS_SEARCH_REJECT_EN
    ,
    input  logic [DIST_W-1:0]      reject_thresh,
    output logic                   pred_reject
`endif
);

    localparam int PC_W = $clog2(FRAME_W + 1);
    localparam logic [CLASS_ID_W-1:0]  LAST_ID  = CLASS_ID_W'(NUM_CLASSES - 1);
    localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic                  s1_valid, s1_first, s1_last, s1_final;
    logic [PC_W-1:0]       s1_pc;
    logic [CLASS_ID_W-1:0] s1_class;
    logic                  s2_final;
    logic [DIST_W-1:0]     acc, acc_next, best_dist;
    logic [CLASS_ID_W-1:0] best_class;
    logic                  at_last_frame, at_last_addr;

    function automatic logic [PC_W-1:0] popcount(input logic [FRAME_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    assign at_last_frame = (rom_frame_index == LAST_IDX);
    assign at_last_addr  = at_last_frame && (rom_frame_id == LAST_ID);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (at_last_addr) state_next = DRAIN;
            DRAIN:   if (s2_final) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address walk; holds its last value outside RUN so the ROM may read freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_frame_id    <= '0;
            rom_frame_index <= '0;
        end else if (state == IDLE && start) begin
            rom_frame_id    <= '0;
            rom_frame_index <= '0;
        end else if (state == RUN && !at_last_addr) begin
            if (at_last_frame) begin
                rom_frame_index <= '0;
                rom_frame_id    <= rom_frame_id + 1'b1;
            end else begin
                rom_frame_index <= rom_frame_index + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_final <= 1'b0;
            s1_pc    <= '0;
            s1_class <= '0;
        end else begin
            s1_valid <= (state == RUN);
            s1_first <= (rom_frame_index == '0);
            s1_last  <= at_last_frame;
            s1_final <= at_last_addr;
            s1_pc    <= popcount(query_frame ^ rom_class_vec);
            s1_class <= rom_frame_id;
        end
    end

    assign acc_next = (s1_first ? '0 : acc) + DIST_W'(s1_pc);

    // Strict less-than keeps the lower class id on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            best_dist  <= '0;
            best_class <= '0;
            s2_final   <= 1'b0;
        end else begin
            s2_final <= s1_valid && s1_final;
            if (s1_valid) begin
                acc <= acc_next;
                if (s1_last && (s1_class == '0 || acc_next < best_dist)) begin
                    best_dist  <= acc_next;
                    best_class <= s1_class;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_class <= '0;
            pred_dist  <= '0;
        end else if (state == DRAIN && s2_final) begin
            pred_class <= best_class;
            pred_dist  <= best_dist;
        end
    end

`ifdef CLASS_SEARCH_REJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_reject <= 1'b0;
        end else if (state == DRAIN && s2_final) begin
            pred_reject <= (best_dist > reject_thresh);
        end
    end
`endif

endmodule

// File: tb/tb_class_search_ctrl.sv
// tb/tb_class_search_ctrl.sv - directed self-checking bench for class_search_ctrl
module tb_class_search_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [2:0]  rom_frame_id;
    logic [1:0]  rom_frame_index;
    logic [63:0] rom_class_vec;
    logic [63:0] query_frame;
    logic        done;
    logic [2:0]  pred_class;
    logic [7:0]  pred_dist;
`ifdef CLASS_SEARCH_REJECT_EN
    logic [7:0]  reject_thresh;
    logic        pred_reject;
`endif

    logic [63:0] rom [0:7][0:2];
    logic [63:0] query [0:2];
    int total = 0;
    int bad   = 0;
    int lat1, lat2, ndone;
    logic busy_first, busy_after;

    always #5 clk = ~clk;

    assign rom_class_vec = (rom_frame_index < 2'd3) ? rom[rom_frame_id][rom_frame_index] : 64'd0;
    assign query_frame   = (rom_frame_index < 2'd3) ? query[rom_frame_index] : 64'd0;

    class_search_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .busy            (busy),
        .rom_frame_id    (rom_frame_id),
        .rom_frame_index (rom_frame_index),
        .rom_class_vec   (rom_class_vec),
        .query_frame     (query_frame),
        .done            (done),
        .pred_class      (pred_class),
        .pred_dist       (pred_dist)
`ifdef CLASS_SEARCH_REJECT_EN
        ,
        .reject_thresh   (reject_thresh),
        .pred_reject     (pred_reject)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_rom();
        logic [63:0] x;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 3; f++) begin
                x = 64'(c * 3 + f + 1) * 64'h9E37_79B9_7F4A_7C15;
                rom[c][f] = x ^ (x >> 29) ^ (x << 17);
            end
        end
    endtask

    task automatic set_query(input int c);
        for (int f = 0; f < 3; f++) query[f] = rom[c][f];
    endtask

    // Pulses start, then watches 64 cycles. k counts edges after the start edge.
    task automatic do_search(input int restart_k, input bit chain, input bit chk_addr);
        lat1 = -1; lat2 = -1; ndone = 0;
        busy_first = 1'b0; busy_after = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 64; k++) begin
            if (k == 0) busy_first = busy;
            if (chk_addr && k < 24) begin
                chk($sformatf("addr_id_k%0d", k), 64'(rom_frame_id), 64'(k / 3));
                chk($sformatf("addr_idx_k%0d", k), 64'(rom_frame_index), 64'(k % 3));
            end
            if (lat1 >= 0 && k == lat1 + 1) busy_after = busy;
            if (done) begin
                ndone++;
                if (lat1 < 0) lat1 = k;
                else if (lat2 < 0) lat2 = k;
            end
            start = (k == restart_k) || (chain && lat1 >= 0 && k == lat1 + 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
`ifdef CLASS_SEARCH_REJECT_EN
        reject_thresh = 8'd255;
`endif
        fill_rom();
        set_query(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_class", 64'(pred_class), 64'd0);
        chk("rst_dist", 64'(pred_dist), 64'd0);
        chk("rst_addr", 64'({rom_frame_id, rom_frame_index}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact match on class 2
        set_query(2);
        do_search(-1, 1'b0, 1'b0);
        chk("t1_latency", 64'(lat1), 64'd26);
        chk("t1_busy_start", 64'(busy_first), 64'd1);
        chk("t1_busy_after", 64'(busy_after), 64'd0);
        chk("t1_ndone", 64'(ndone), 64'd1);
        chk("t1_class", 64'(pred_class), 64'd2);
        chk("t1_dist", 64'(pred_dist), 64'd0);

        // Class 5 with one flipped bit, plus the address walk
        set_query(5);
        query[1][17] = ~query[1][17];
        do_search(-1, 1'b0, 1'b1);
        chk("t2_latency", 64'(lat1), 64'd26);
        chk("t2_class", 64'(pred_class), 64'd5);
        chk("t2_dist", 64'(pred_dist), 64'd1);

        // Tie between classes 3 and 6
        for (int f = 0; f < 3; f++) rom[6][f] = rom[3][f];
        set_query(3);
        do_search(-1, 1'b0, 1'b0);
        chk("t3_class", 64'(pred_class), 64'd3);
        chk("t3_dist", 64'(pred_dist), 64'd0);
        fill_rom();

        // Start mid-search is ignored
        set_query(7);
        do_search(10, 1'b0, 1'b0);
        chk("t4_ndone", 64'(ndone), 64'd1);
        chk("t4_latency", 64'(lat1), 64'd26);
        chk("t4_class", 64'(pred_class), 64'd7);

        // Start in the cycle after done is accepted
        set_query(1);
        do_search(-1, 1'b1, 1'b0);
        chk("t5_ndone", 64'(ndone), 64'd2);
        chk("t5_lat2", 64'(lat2), 64'd54);
        chk("t5_class", 64'(pred_class), 64'd1);

        // Reset mid-search
        set_query(5);
        query[1][17] = ~query[1][17];
        do_search(-1, 1'b0, 1'b0);
        chk("t6_pre_class", 64'(pred_class), 64'd5);
        set_query(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_class", 64'(pred_class), 64'd0);
        chk("t6_dist", 64'(pred_dist), 64'd0);
        chk("t6_addr", 64'({rom_frame_id, rom_frame_index}), 64'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (k == 2) rst_n = 1'b1;
        end
        chk("t6_no_done", 64'(ndone), 64'd0);
        do_search(-1, 1'b0, 1'b0);
        chk("t6_after_latency", 64'(lat1), 64'd26);
        chk("t6_after_class", 64'(pred_class), 64'd4);
        chk("t6_after_dist", 64'(pred_dist), 64'd0);

`ifdef CLASS_SEARCH_REJECT_EN
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++) rom[c][f] = '1;
        for (int f = 0; f < 3; f++) query[f] = '0;
        reject_thresh = 8'd100;
        do_search(-1, 1'b0, 1'b0);
        chk("rj_dist", 64'(pred_dist), 64'd192);
        chk("rj_class", 64'(pred_class), 64'd0);
        chk("rj_reject_hi", 64'(pred_reject), 64'd1);
        reject_thresh = 8'd192;
        do_search(-1, 1'b0, 1'b0);
        chk("rj_reject_lo", 64'(pred_reject), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/class_search_ctrl.md
Name: class_search_ctrl

Overview:
Sequencer that drives the class hypervector ROM (frame_id/frame_index address, 64-bit frame data) to classify one query hypervector. It walks every class and every frame, computes per-frame Hamming distance (XOR + popcount), accumulates per class, and tracks the arg-min. It sits between the query buffer and the result register file in the inference path.

Parameters:
NUM_CLASSES, 8, number of classes (frame_id range 0..NUM_CLASSES-1)
NUM_FRAMES, 3, frames per hypervector (frame_index range 0..NUM_FRAMES-1)
FRAME_W, 64, bits per frame
CLASS_ID_W, 3, width of frame_id / class id, >= clog2(NUM_CLASSES)
FRAME_IDX_W, 2, width of frame_index, >= clog2(NUM_FRAMES)
DIST_W, 8, distance width, >= clog2(NUM_FRAMES*FRAME_W+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a search; sampled only in IDLE
busy  out  1  high from the edge after start until done
rom_frame_id  out  CLASS_ID_W  class address to ROM
rom_frame_index  out  FRAME_IDX_W  frame address to ROM, also to query buffer
rom_class_vec  in  FRAME_W  combinational ROM data for current address
query_frame  in  FRAME_W  combinational query-buffer data for rom_frame_index
done  out  1  one-cycle pulse, result valid
pred_class  out  CLASS_ID_W  class with minimum distance
pred_dist  out  DIST_W  minimum distance

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, pred_class=0, pred_dist=0, rom_frame_id=0, rom_frame_index=0, accumulators cleared, pipeline valid cleared. Reset mid-search aborts immediately; no done pulse.
- FSM: IDLE -> RUN on start=1; RUN -> DRAIN after the address (NUM_CLASSES-1, NUM_FRAMES-1) is issued; DRAIN -> DONE once the last pipeline stage has retired; DONE -> IDLE unconditionally after 1 cycle.
- RUN: one address per cycle, frame_index inner loop (0..NUM_FRAMES-1), frame_id outer loop; addresses registered; wrap frame_index to 0 and increment frame_id.
- Stage 1 (registered): pc = popcount(query_frame ^ rom_class_vec), width clog2(FRAME_W+1), tagged with class id, first-frame flag and last-frame flag.
- Stage 2: acc = (first ? 0 : acc) + pc, zero-extended to DIST_W, no saturation needed. On last frame: if class 0, or acc_next < best_dist strictly, then best_dist <= acc_next and best_class <= tag. Ties keep the lower class id.
- Latency: start sampled at edge E0; done=1 during the cycle after edge E(NUM_CLASSES*NUM_FRAMES+2), i.e. 26 cycles for the defaults. pred_class/pred_dist update at the same edge as done and hold until the next search completes.
- busy=1 in RUN/DRAIN/DONE; start is ignored while busy, including during the done cycle. A start in the cycle after done is accepted.
- rom_frame_id/index hold their last value in IDLE (ROM may read freely); query_frame must be stable for the whole search.

Optional Feature:
CLASS_SEARCH_REJECT_EN: adds input reject_thresh [DIST_W-1:0] and output pred_reject (reset 0), registered with done. pred_reject=1 when best distance > reject_thresh, else 0. Undefined macro: both ports are absent and every result is accepted; all other timing is identical.

Test Plan:
- Query = class 2 frames exactly, start pulse -> done exactly 26 cycles after the start edge, pred_class=2, pred_dist=0, busy low the cycle after done.
- Query = class 5 frames with bit 17 of frame 1 flipped -> pred_class=5, pred_dist=1. Check the address sequence (0,0),(0,1),(0,2),(1,0)...(7,2), one address per cycle.
- Stub ROM with classes 3 and 6 identical and equal to the query -> pred_class=3, pred_dist=0 (tie goes to the lower id).
- Second start pulse at cycle 10 of a search -> ignored, only one done pulse. Start on the cycle after done -> second search, done 26 cycles later.
- rst_n low at cycle 12 of a search -> busy=0, done never pulses, outputs 0. A fresh search after reset returns the correct result.
- REJECT_EN, stub ROM with all-ones frames, query all zeros, reject_thresh=100 -> pred_dist=192, pred_reject=1. With reject_thresh=192 -> pred_reject=0.
